// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and helpers for the instruction fetch sequencer.
package fetch_pkg;

    typedef enum logic [1:0] {
        FS_IDLE,
        FS_RUN,
        FS_DRAIN,
        FS_FAULT
    } fetch_state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } fetch_entry_t;

    localparam int INST_BYTES = 4;

    // A fetch PC is legal when word aligned and inside the instruction memory.
    function automatic logic pc_legal(input logic [31:0] pc, input int unsigned depth);
        return (pc[1:0] == 2'b00) && ((pc >> 2) < depth);
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: small power-of-two FIFO of {pc, inst} entries with flush.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_push,
    input  logic         i_pop,
    input  logic         i_flush,
    input  fetch_entry_t i_data,
    output fetch_entry_t o_head,
    output logic [CW-1:0] o_count,
    output logic         o_full,
    output logic         o_empty
);

    fetch_entry_t  r_mem [DEPTH];
    logic [AW-1:0] r_wr;
    logic [AW-1:0] r_rd;
    logic [CW-1:0] r_count;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else if (i_flush) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
        end else begin
            if (i_push) begin
                r_mem[r_wr] <= i_data;
                r_wr        <= r_wr + AW'(1);
            end
            if (i_pop) r_rd <= r_rd + AW'(1);
            r_count <= r_count + CW'(i_push) - CW'(i_pop);
        end
    end

    assign o_head  = r_mem[r_rd];
    assign o_count = r_count;
    assign o_full  = r_count == CW'(DEPTH);
    assign o_empty = r_count == '0;

endmodule

// File: rtl/imem_fetch_ctrl.sv
// imem_fetch_ctrl: PC sequencer feeding a fetch FIFO from a combinational instruction memory.
module imem_fetch_ctrl
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          IMEM_DEPTH = 1024,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        halt_req,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_inst,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst_out,
    output logic [31:0] inst_pc,
    output logic        fetch_fault,
    output logic        busy
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    fetch_state_t  r_state;
    logic [31:0]   r_pc;
    fetch_entry_t  w_head;
    logic [CW-1:0] w_count;
    logic          w_full;
    logic          w_empty;
    logic          w_pop;
    logic          w_try;
    logic          w_push;
    logic          w_fault;

    // Redirect and halt both suppress fetching; the fault is only raised when a push would occur.
    assign w_pop   = !w_empty && inst_ready && !redirect_valid;
    assign w_try   = (r_state == FS_RUN) && !redirect_valid && !halt_req && (!w_full || w_pop);
    assign w_push  = w_try && pc_legal(r_pc, IMEM_DEPTH);
    assign w_fault = w_try && !pc_legal(r_pc, IMEM_DEPTH);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= FS_IDLE;
            r_pc    <= RESET_PC;
        end else begin
            if (redirect_valid) r_pc <= redirect_pc;
            else if (w_push)    r_pc <= r_pc + 32'(INST_BYTES);
            case (r_state)
                FS_IDLE:  if (start && !redirect_valid) r_state <= FS_RUN;
                FS_RUN:   if (halt_req) r_state <= FS_DRAIN;
                          else if (w_fault) r_state <= FS_FAULT;
                FS_DRAIN: if (w_count == '0 && !redirect_valid) r_state <= FS_IDLE;
                FS_FAULT: if (redirect_valid && pc_legal(redirect_pc, IMEM_DEPTH)) r_state <= FS_RUN;
                default:  r_state <= FS_IDLE;
            endcase
        end
    end

    fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_flush (redirect_valid),
        .i_data  ('{pc: r_pc, inst: imem_inst}),
        .o_head  (w_head),
        .o_count (w_count),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    assign imem_addr   = r_pc >> 2;
    assign inst_valid  = !w_empty;
    assign inst_out    = w_head.inst;
    assign inst_pc     = w_head.pc;
    assign fetch_fault = r_state == FS_FAULT;
    assign busy        = (r_state != FS_IDLE) || !w_empty;

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// tb_imem_fetch_ctrl: directed stimulus with a queue-based reference model checked every cycle.
module tb_imem_fetch_ctrl;

    localparam int DEPTH = 2;
    localparam int M_IDLE = 0, M_RUN = 1, M_DRAIN = 2, M_FAULT = 3;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } ent_t;

    logic        clk = 0;
    logic        rst_n = 0;
    logic        start = 0;
    logic        halt_req = 0;
    logic        redirect_valid = 0;
    logic [31:0] redirect_pc = 0;
    logic [31:0] imem_addr;
    logic [31:0] imem_inst;
    logic        inst_valid;
    logic        inst_ready = 0;
    logic [31:0] inst_out;
    logic [31:0] inst_pc;
    logic        fetch_fault;
    logic        busy;

    logic [31:0] mem [1024];
    int          tests = 0;
    int          fails = 0;

    ent_t        mq[$];
    logic [31:0] m_pc;
    int          m_mode;
    logic [31:0] log_pc[$];

    imem_fetch_ctrl dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .halt_req       (halt_req),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_addr      (imem_addr),
        .imem_inst      (imem_inst),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst_out       (inst_out),
        .inst_pc        (inst_pc),
        .fetch_fault    (fetch_fault),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    always_comb imem_inst = (imem_addr < 32'd1024) ? mem[imem_addr[9:0]] : 32'hDEAD_BEEF;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic bit legal(input logic [31:0] pc);
        return (pc % 4 == 0) && (pc / 4 < 1024);
    endfunction

    // Reference: a queue of buffered {pc, inst} plus the fetch PC and mode.
    task automatic model_step();
        int n0;
        n0 = mq.size();
        if (redirect_valid) begin
            mq.delete();
            m_pc = redirect_pc;
            if (m_mode == M_FAULT && legal(redirect_pc)) m_mode = M_RUN;
            else if (m_mode == M_RUN && halt_req) m_mode = M_DRAIN;
        end else begin
            if (n0 > 0 && inst_ready) void'(mq.pop_front());
            case (m_mode)
                M_IDLE:  if (start) m_mode = M_RUN;
                M_RUN:   if (halt_req) m_mode = M_DRAIN;
                         else if (mq.size() < DEPTH) begin
                             if (legal(m_pc)) begin
                                 mq.push_back('{pc: m_pc, inst: mem[m_pc[11:2]]});
                                 m_pc = m_pc + 4;
                             end else m_mode = M_FAULT;
                         end
                M_DRAIN: if (n0 == 0) m_mode = M_IDLE;
                default: ;
            endcase
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mq.delete();
            m_pc   = 32'h0;
            m_mode = M_IDLE;
        end else model_step();
    end

    always @(negedge clk) begin
        if (rst_n) begin
            check("valid", 32'(inst_valid), 32'(mq.size() > 0));
            check("imem_addr", imem_addr, m_pc >> 2);
            check("fault", 32'(fetch_fault), 32'(m_mode == M_FAULT));
            check("busy", 32'(busy), 32'(m_mode != M_IDLE || mq.size() > 0));
            if (mq.size() > 0) begin
                check("head_pc", inst_pc, mq[0].pc);
                check("head_inst", inst_out, mq[0].inst);
            end
            if (inst_valid && inst_ready && !redirect_valid) log_pc.push_back(inst_pc);
        end
    end

    task automatic nxt(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_reset_vals();
        check("rst_valid", 32'(inst_valid), 0);
        check("rst_out", inst_out, 0);
        check("rst_pc", inst_pc, 0);
        check("rst_fault", 32'(fetch_fault), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_addr", imem_addr, 0);
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 32'hA000_0000 | i;
        mem[0] = 32'h0020_8033;
        mem[1] = 32'h4020_8033;

        nxt(2);
        check_reset_vals();
        rst_n = 1;

        // Start latency and streaming
        inst_ready = 1;
        nxt();
        start = 1;
        nxt();
        start = 0;
        check("c1_valid", 32'(inst_valid), 0);
        nxt();
        check("c2_valid", 32'(inst_valid), 1);
        check("c2_pc", inst_pc, 32'h0);
        check("c2_inst", inst_out, 32'h0020_8033);
        nxt();
        check("c3_pc", inst_pc, 32'h4);
        check("c3_inst", inst_out, 32'h4020_8033);
        nxt();
        check("c4_pc", inst_pc, 32'h8);

        // Backpressure from a fresh start
        rst_n = 0;
        inst_ready = 0;
        nxt(2);
        rst_n = 1;
        nxt();
        start = 1;
        nxt();
        start = 0;
        nxt(4);
        check("stall_head", inst_pc, 32'h0);
        check("stall_addr", imem_addr, 32'h2);
        log_pc.delete();
        inst_ready = 1;
        nxt(3);
        check("stall_n", log_pc.size(), 3);
        if (log_pc.size() >= 3) begin
            check("stall_0", log_pc[0], 32'h0);
            check("stall_1", log_pc[1], 32'h4);
            check("stall_2", log_pc[2], 32'h8);
        end

        // Redirect with a full FIFO
        inst_ready = 0;
        nxt(3);
        redirect_valid = 1;
        redirect_pc = 32'h40;
        log_pc.delete();
        nxt();
        redirect_valid = 0;
        check("redir_gap", 32'(inst_valid), 0);
        nxt();
        check("redir_valid", 32'(inst_valid), 1);
        check("redir_pc", inst_pc, 32'h40);
        inst_ready = 1;
        nxt(2);
        check("redir_log", log_pc.size() > 0 ? log_pc[0] : 32'hFFFF_FFFF, 32'h40);

        // Misaligned redirect, then recovery
        redirect_valid = 1;
        redirect_pc = 32'h42;
        nxt();
        redirect_valid = 0;
        check("mis_n1_fault", 32'(fetch_fault), 0);
        nxt();
        check("mis_fault", 32'(fetch_fault), 1);
        check("mis_empty", 32'(inst_valid), 0);
        nxt(2);
        check("mis_hold", 32'(fetch_fault), 1);
        check("mis_addr", imem_addr, 32'h10);
        redirect_valid = 1;
        redirect_pc = 32'h10;
        nxt();
        redirect_valid = 0;
        check("rec_fault", 32'(fetch_fault), 0);
        nxt();
        check("rec_pc", inst_pc, 32'h10);
        check("rec_inst", inst_out, 32'hA000_0004);

        // End of memory: last word delivered, fault at 0x1000, buffer drains
        inst_ready = 0;
        redirect_valid = 1;
        redirect_pc = 32'hFF8;
        nxt();
        redirect_valid = 0;
        nxt(2);
        inst_ready = 1;
        log_pc.delete();
        nxt();
        check("eom_fault", 32'(fetch_fault), 1);
        check("eom_valid", 32'(inst_valid), 1);
        check("eom_pc", inst_pc, 32'hFFC);
        check("eom_inst", inst_out, 32'hA000_03FF);
        nxt();
        check("eom_drained", 32'(inst_valid), 0);
        check("eom_log_n", log_pc.size(), 2);
        check("eom_addr", imem_addr, 32'h400);

        // Halt with a full FIFO
        inst_ready = 0;
        redirect_valid = 1;
        redirect_pc = 32'h20;
        nxt();
        redirect_valid = 0;
        nxt(3);
        inst_ready = 1;
        halt_req = 1;
        log_pc.delete();
        nxt();
        halt_req = 0;
        nxt(3);
        check("halt_busy", 32'(busy), 0);
        check("halt_n", log_pc.size(), 2);
        if (log_pc.size() >= 2) begin
            check("halt_0", log_pc[0], 32'h20);
            check("halt_1", log_pc[1], 32'h24);
        end
        check("halt_addr", imem_addr, 32'hA);

        // Async reset mid-RUN
        start = 1;
        nxt();
        start = 0;
        nxt(2);
        #2;
        rst_n = 0;
        #1;
        check_reset_vals();
        nxt(2);
        rst_n = 1;
        nxt(2);
        check("post_rst_busy", 32'(busy), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/imem_fetch_ctrl.md
# imem_fetch_ctrl

Fetch sequencer for the word-indexed, combinational-read instruction memory. Owns the program counter, drives the memory word address, and captures each returned instruction with its PC into a small FIFO. Hands instructions to decode through a valid/ready handshake. Supports start/halt control, branch redirect with flush, and a sticky fault for misaligned or out-of-range fetches.

## Interface
- `RESET_PC`, 32'h0000_0000, byte address of the first fetch after reset.
- `IMEM_DEPTH`, 1024, number of instruction words; a word index ≥ IMEM_DEPTH is out of range.
- `FIFO_DEPTH`, 2, fetch buffer entries; must be a power of two and ≥ 2.
- Reset is asynchronous, active-low, `rst_n`. There is one clock, `clk`.
- `clk`  in  1  system clock, rising edge
- `rst_n`  in  1  asynchronous active-low reset
- `start`  in  1  leave IDLE and begin fetching at the current PC
- `halt_req`  in  1  stop fetching, drain the FIFO, then return to IDLE
- `redirect_valid`  in  1  flush and load a new PC
- `redirect_pc`  in  32  new byte PC
- `imem_addr`  out  32  memory word index, equal to `pc >> 2`
- `imem_inst`  in  32  memory read data, combinational from `imem_addr`
- `inst_valid`  out  1  FIFO head valid
- `inst_ready`  in  1  decode accepts the head
- `inst_out`  out  32  head instruction
- `inst_pc`  out  32  head byte PC
- `fetch_fault`  out  1  high in the FAULT state
- `busy`  out  1  state is not IDLE, or the FIFO is non-empty

## Operation
- The FSM has four states: IDLE, RUN, DRAIN, FAULT.
- IDLE to RUN on `start`. RUN to DRAIN on `halt_req`. DRAIN to IDLE when the FIFO count is 0.
- RUN to FAULT on a fault condition. FAULT to RUN on a redirect with a legal PC.
- Fault condition:
  - `pc[1:0] != 0`, or
  - `pc >> 2 >= IMEM_DEPTH`.
  - It is evaluated only in RUN, when a push would occur. The faulting PC is not pushed.
- Push in RUN when there is no fault and the FIFO has room: count < FIFO_DEPTH, or a pop happens in the same cycle.
  - A push writes {pc, imem_inst} and sets pc ← pc + 4 (32-bit wrap).
- Pop when `inst_valid && inst_ready`.
- A simultaneous push and pop on a full FIFO is legal; the count is unchanged.
- Redirect has priority over everything except reset. Its effects in the same cycle:
  - FIFO flushed (count ← 0).
  - pc ← `redirect_pc`.
  - Any push or pop in that cycle is suppressed.
- Redirect effect on the state:
  - In IDLE: state unchanged.
  - In FAULT: go to RUN if `redirect_pc` is legal; otherwise stay in FAULT.
- Redirect and `halt_req` in the same cycle from RUN: flush, load the PC, go to DRAIN. DRAIN sees an empty FIFO and reaches IDLE on the next cycle.
- `start` in a non-IDLE state and `halt_req` in IDLE or DRAIN are ignored.
- In FAULT, already-buffered entries still drain to decode. `fetch_fault` stays high until a legal redirect or reset.
- Reset may assert mid-operation and takes effect immediately. Reset values:
  - state IDLE, pc = RESET_PC, count 0.
  - `inst_valid` 0, `inst_out` 0, `inst_pc` 0, `fetch_fault` 0, `busy` 0.
  - `imem_addr` = RESET_PC >> 2.
- When `inst_valid` is 0, `inst_out` and `inst_pc` hold their last values. These values are don't-care for checks.

## Timing
- Memory is combinational. The instruction at `imem_addr` is captured at the rising edge that ends the cycle.
- Start latency:
  - `start` high in cycle 0.
  - RUN in cycle 1, which pushes RESET_PC.
  - `inst_valid` = 1 in cycle 2.
- Redirect latency:
  - `redirect_valid` in cycle N.
  - `inst_valid` = 0 in cycle N+1, and `redirect_pc` is pushed in N+1.
  - `inst_valid` = 1 with `inst_pc` = `redirect_pc` in N+2.
- Throughput is one instruction per cycle while `inst_ready` = 1.
- Output changes are registered. The only combinational path from input to output is `imem_inst`, which reaches `inst_out` through the FIFO on the next cycle.

## Structure
- Package `fetch_pkg` holds:
  - `fetch_state_t` enum: FS_IDLE, FS_RUN, FS_DRAIN, FS_FAULT.
  - `fetch_entry_t` struct: pc[31:0], inst[31:0].
  - Constant `INST_BYTES` = 4.
- Sub-module `fetch_fifo`, parameterised by FIFO_DEPTH:
  - Inputs: push, pop, flush.
  - Outputs: head, count, full, empty.
  - Pointer wrap-around via power-of-two indexing.
- The top level holds the FSM, the PC register and the fault checks.

## Test plan
- Reset with RESET_PC=0, then `start`, with words 0..1 preloaded = 32'h0020_8033 and 32'h4020_8033, `inst_ready`=1 → cycle 2 {pc 0, 32'h0020_8033}, cycle 3 {pc 4, 32'h4020_8033}, one per cycle thereafter.
- Hold `inst_ready`=0 for 5 cycles after start → at most FIFO_DEPTH=2 entries, pc stalls at 8, head stays at pc 0. Release → pcs 0, 4, 8 in order with no loss or duplicates.
- Redirect to 32'h40 while the FIFO holds 2 entries → `inst_valid`=0 next cycle, then `inst_pc`=32'h40. Old entries never appear.
- Redirect to 32'h42 → FAULT in the following cycle, `fetch_fault`=1, nothing pushed. Redirect to 32'h10 → RUN, `fetch_fault`=0, `inst_pc`=32'h10.
- Run pc up to 4*(IMEM_DEPTH-1)=32'hFFC → word 1023 delivered, then FAULT at pc 32'h1000. Buffered entries still drain.
- Assert `halt_req` with a full FIFO and `inst_ready`=1 → no new pushes, 2 pops, IDLE, `busy`=0. Then async reset mid-RUN → all outputs at reset values immediately.
